data_memory_responder: RTL
==========================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5, giving busy cycles per access after acceptance (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_BITS, default 8, giving log2 of the number of 128-bit blocks stored.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port mem_read, input, 1 bit: block read request, held by the initiator until busywait falls.
REQ-006 The block SHALL have port mem_write, input, 1 bit: block write request, held by the initiator until busywait falls.
REQ-007 The block SHALL have port mem_address, input, 28 bits: block address; bits [DEPTH_BITS-1:0] index storage, upper bits ignored.
REQ-008 The block SHALL have port mem_writedata, input, 128 bits: write block, word 0 in bits [31:0].
REQ-009 The block SHALL have port mem_readdata, output, 128 bits: registered read block, same word order.
REQ-010 The block SHALL have port mem_busywait, output, 1 bit: high while a request is pending or in service.

Function
REQ-011 The block SHALL implement states IDLE, BUSY and DONE.
REQ-012 In IDLE, mem_busywait SHALL equal (mem_read OR mem_write) combinationally, so it is high in the same cycle the request appears.
REQ-013 On a rising edge in IDLE with a request present, the block SHALL latch index, op and writedata, load its counter with LATENCY-1 and enter BUSY.
REQ-014 If mem_read and mem_write are both high at acceptance, the block SHALL service the write only.
REQ-015 In BUSY, mem_busywait SHALL be 1 and the counter SHALL decrement each cycle.
REQ-016 On the BUSY edge where the counter is 0, the block SHALL perform the access (read: mem_readdata <= storage[index]; write: storage[index] <= latched data) and enter DONE.
REQ-017 Net timing SHALL be: busywait high for exactly LATENCY+1 cycles, from the request cycle through the last BUSY cycle.
REQ-018 In DONE, mem_busywait SHALL be 0 for exactly one cycle, mem_readdata SHALL hold the read result, and the block SHALL return to IDLE on the next edge regardless of the inputs.
REQ-019 A request still high during DONE SHALL NOT be re-serviced.
REQ-020 Request inputs dropping during BUSY SHALL NOT abort the access; it completes per REQ-016.
REQ-021 mem_readdata SHALL change only on a read completion or on reset; write accesses leave it unchanged.
REQ-022 Storage contents SHALL be undefined until first written; reset does not clear them.

Reset
REQ-023 With reset low at a rising edge, the block SHALL enter IDLE, clear the counter to 0 and set mem_readdata to 0.
REQ-024 Asserting reset mid-BUSY SHALL abandon the access: no storage write, and mem_readdata is cleared.
REQ-025 While reset is low, mem_busywait SHALL follow IDLE behaviour.

Configuration
REQ-026 With DMEM_ACCESS_COUNT_EN defined, the block SHALL add 32-bit outputs read_count and write_count.
REQ-027 read_count and write_count SHALL each increment at the matching completion (REQ-016), wrap at 2^32 and reset to 0.
REQ-028 Without DMEM_ACCESS_COUNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the 128-bit block type and the 28-bit block-address width constant.
REQ-030 Storage SHALL be a single sub-module dmem_block_array: 2^DEPTH_BITS x 128, one synchronous write port and one synchronous read port.

Verification
REQ-031 Write test: LATENCY=5, mem_write=1, mem_address=28'h0000012, data 128'hDEADBEEF_0 -> busywait high for 6 cycles, then low for 1 cycle; a later read of 28'h12 returns the same 128-bit value.
REQ-032 Read/alias test: write 28'hABC0001, then read 28'h0000001 with DEPTH_BITS=8 -> identical data (upper address bits ignored).
REQ-033 Held request: hold mem_read high for 3 cycles past DONE -> second access starts only after DONE; busywait low for exactly 1 cycle between the two accesses.
REQ-034 Simultaneous request: read=write=1 with data 128'h1 -> storage written with 128'h1; mem_readdata unchanged.
REQ-035 Reset in the 3rd BUSY cycle of a write -> IDLE on the next edge; mem_readdata=0; old block contents intact on a subsequent read.
REQ-036 With DMEM_ACCESS_COUNT_EN defined: 2 reads, 3 writes -> read_count=2 and write_count=3; both read 0 after reset.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data memory responder.
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - 128-bit block type and the 28-bit block-address width
//   - latched request record used by the top level
package data_memory_responder_pkg;

  localparam int BLK_ADDR_W = 28;
  localparam int BLK_W      = 128;

  typedef logic [BLK_W-1:0] block_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Operation captured at acceptance; index is held separately since its
  // width depends on the DEPTH_BITS parameter.
  typedef struct packed {
    logic   wr;
    block_t data;
  } req_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Block memory bus between an initiator (master) and the responder (slave).
//   mem_read/mem_write : request strobes, held until busywait falls
//   mem_address        : 28-bit block address
//   mem_writedata      : write block, word 0 in [31:0]
//   mem_readdata       : registered read block
//   mem_busywait       : request pending or in service
interface data_memory_responder_if;
  import data_memory_responder_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [BLK_ADDR_W-1:0] mem_address;
  block_t                mem_writedata;
  block_t                mem_readdata;
  logic                  mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/data_memory_responder_block_array.sv
// dmem_block_array: 2^DEPTH_BITS x 128-bit storage.
//   clock        : rising-edge clock
//   reset        : sync active-low; clears only the read register, never storage
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port, rdata holds until the next read
module dmem_block_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  block_t                wdata,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] raddr,
  output block_t                rdata
);

  block_t mem [2**DEPTH_BITS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency 128-bit block memory.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   bus (slave)  : read/write request, address, write/read data, busywait
//   read_count, write_count : completed-access counters, present only when
//                             DMEM_ACCESS_COUNT_EN is defined
// A request is accepted in IDLE, serviced after LATENCY BUSY cycles, then a
// single DONE cycle drops busywait so a held request is not re-serviced.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int LATENCY    = 5,
  parameter int DEPTH_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
`endif
);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [DEPTH_BITS-1:0] idx;
  req_t                  req_q;
  logic                  req_in;
  logic                  fire;

  assign req_in = bus.mem_read | bus.mem_write;
  assign fire   = (state == ST_BUSY) && (cnt == 4'd0);

  // Only the low DEPTH_BITS of the address select a block.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_address[BLK_ADDR_W-1:DEPTH_BITS];

  // IDLE answers combinationally so busywait rises in the request cycle;
  // while reset is held the block is treated as idle.
  always_comb begin
    bus.mem_busywait = 1'b0;
    if (!reset || state == ST_IDLE) bus.mem_busywait = req_in;
    else if (state == ST_BUSY)      bus.mem_busywait = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (req_in) begin
          state      <= ST_BUSY;
          cnt        <= 4'(LATENCY - 1);
          idx        <= bus.mem_address[DEPTH_BITS-1:0];
          req_q.wr   <= bus.mem_write;   // write wins when both strobes are up
          req_q.data <= bus.mem_writedata;
        end
        ST_BUSY: begin
          if (cnt == 4'd0) state <= ST_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps a reset that lands on the completion edge from
  // committing the write.
  dmem_block_array #(.DEPTH_BITS(DEPTH_BITS)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (fire & req_q.wr & reset),
    .waddr (idx),
    .wdata (req_q.data),
    .re    (fire & ~req_q.wr),
    .raddr (idx),
    .rdata (bus.mem_readdata)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (fire) begin
      if (req_q.wr) write_count <= write_count + 32'd1;
      else          read_count  <= read_count + 32'd1;
    end
  end
`endif

endmodule
